// File: rtl/cov_accumulator.sv
// Covariance mean stage: accumulates the 10 unique pairwise products over N_SAMPLES
// accepted samples, then commits floor(sum / N) as registered, held covariance terms.
module cov_accumulator #(
  parameter int IN_W      = 52,
  parameter int LOG2_N    = 7,
  parameter int N_SAMPLES = 128,
  parameter int ACC_W     = IN_W + LOG2_N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] X1X1,
  input  logic signed [IN_W-1:0] X1X2,
  input  logic signed [IN_W-1:0] X1X3,
  input  logic signed [IN_W-1:0] X1X4,
  input  logic signed [IN_W-1:0] X2X2,
  input  logic signed [IN_W-1:0] X2X3,
  input  logic signed [IN_W-1:0] X2X4,
  input  logic signed [IN_W-1:0] X3X3,
  input  logic signed [IN_W-1:0] X3X4,
  input  logic signed [IN_W-1:0] X4X4,
  output logic signed [IN_W-1:0] C11,
  output logic signed [IN_W-1:0] C12,
  output logic signed [IN_W-1:0] C13,
  output logic signed [IN_W-1:0] C14,
  output logic signed [IN_W-1:0] C22,
  output logic signed [IN_W-1:0] C23,
  output logic signed [IN_W-1:0] C24,
  output logic signed [IN_W-1:0] C33,
  output logic signed [IN_W-1:0] C34,
  output logic signed [IN_W-1:0] C44,
  output logic                   busy,
  output logic                   done
);

  localparam int NUM_TERMS = 10;
  localparam int CNT_W     = LOG2_N + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIN
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic signed [ACC_W-1:0]  acc_q [NUM_TERMS];
  logic signed [ACC_W-1:0]  acc_d [NUM_TERMS];
  logic signed [IN_W-1:0]   c_q   [NUM_TERMS];
  logic signed [IN_W-1:0]   c_d   [NUM_TERMS];
  logic signed [IN_W-1:0]   in_vec [NUM_TERMS];

  assign in_vec[0] = X1X1;
  assign in_vec[1] = X1X2;
  assign in_vec[2] = X1X3;
  assign in_vec[3] = X1X4;
  assign in_vec[4] = X2X2;
  assign in_vec[5] = X2X3;
  assign in_vec[6] = X2X4;
  assign in_vec[7] = X3X3;
  assign in_vec[8] = X3X4;
  assign in_vec[9] = X4X4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_TERMS; i++) begin
        acc_q[i] <= '0;
        c_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
    end
  end

  // start always wins over in_valid; in FIN the results are committed even when start restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    acc_d   = acc_q;
    c_d     = c_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_TERMS; i++) acc_d[i] = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end

      ACC: begin
        if (start) begin
          for (int i = 0; i < NUM_TERMS; i++) acc_d[i] = '0;
          cnt_d = '0;
        end else if (in_valid) begin
          for (int i = 0; i < NUM_TERMS; i++) begin
            acc_d[i] = acc_q[i] + {{(ACC_W - IN_W){in_vec[i][IN_W-1]}}, in_vec[i]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = FIN;
        end
      end

      FIN: begin
        // Taking bits above LOG2_N is the arithmetic shift (floor) truncated to IN_W.
        for (int i = 0; i < NUM_TERMS; i++) c_d[i] = acc_q[i][LOG2_N +: IN_W];
        done_d  = 1'b1;
        state_d = IDLE;
        if (start) begin
          for (int i = 0; i < NUM_TERMS; i++) acc_d[i] = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  assign C11 = c_q[0];
  assign C12 = c_q[1];
  assign C13 = c_q[2];
  assign C14 = c_q[3];
  assign C22 = c_q[4];
  assign C23 = c_q[5];
  assign C24 = c_q[6];
  assign C33 = c_q[7];
  assign C34 = c_q[8];
  assign C44 = c_q[9];

endmodule

// File: tb/tb_cov_accumulator.sv
// Scoreboard bench for cov_accumulator: expected covariance means are pushed when a run's
// samples have been driven and popped when the DUT pulses done.
module tb_cov_accumulator;

  localparam int IN_W   = 52;
  localparam int LOG2_N = 7;
  localparam int ACC_W  = IN_W + LOG2_N;

  typedef logic [9:0][IN_W-1:0] vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  vec_t             x_tb;
  logic [IN_W-1:0]  c_w [10];
  logic             busy;
  logic             done;

  logic signed [ACC_W-1:0] model_acc [10];
  vec_t exp_q [$];
  int   compared   = 0;
  int   mismatched = 0;
  int   done_count = 0;
  string nm [10] = '{"C11", "C12", "C13", "C14", "C22", "C23", "C24", "C33", "C34", "C44"};

  always #5 clk = ~clk;

  cov_accumulator dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .X1X1     (x_tb[0]),
    .X1X2     (x_tb[1]),
    .X1X3     (x_tb[2]),
    .X1X4     (x_tb[3]),
    .X2X2     (x_tb[4]),
    .X2X3     (x_tb[5]),
    .X2X4     (x_tb[6]),
    .X3X3     (x_tb[7]),
    .X3X4     (x_tb[8]),
    .X4X4     (x_tb[9]),
    .C11      (c_w[0]),
    .C12      (c_w[1]),
    .C13      (c_w[2]),
    .C14      (c_w[3]),
    .C22      (c_w[4]),
    .C23      (c_w[5]),
    .C24      (c_w[6]),
    .C33      (c_w[7]),
    .C34      (c_w[8]),
    .C44      (c_w[9]),
    .busy     (busy),
    .done     (done)
  );

  // Counts done pulses independently of the main sequence so stray pulses are caught.
  always @(posedge clk) begin
    if (done === 1'b1) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_const(input string tag, input int ch, input logic [IN_W-1:0] val);
    checkOutput(tag, {12'b0, c_w[ch]}, {12'b0, val});
  endtask

  function automatic vec_t all_of(input logic [IN_W-1:0] val);
    vec_t v;
    for (int ch = 0; ch < 10; ch++) v[ch] = val;
    return v;
  endfunction

  task automatic model_clear();
    for (int ch = 0; ch < 10; ch++) model_acc[ch] = '0;
  endtask

  task automatic do_start(input bit with_valid);
    @(negedge clk);
    start    = 1'b1;
    in_valid = with_valid;
    x_tb     = all_of(IN_W'(12345));
    model_clear();
  endtask

  // gap idle cycles precede each sample, so the last action is always an accepted sample.
  task automatic applyStimulus(input vec_t v, input int n, input int gap, input bit rnd);
    logic [63:0] r;
    for (int s = 0; s < n; s++) begin
      repeat (gap) begin
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
      end
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      for (int ch = 0; ch < 10; ch++) begin
        if (rnd) begin
          r = {$urandom(), $urandom()};
          x_tb[ch] = r[IN_W-1:0];
        end else begin
          x_tb[ch] = v[ch];
        end
        model_acc[ch] = model_acc[ch] + ACC_W'(signed'(x_tb[ch]));
      end
    end
  endtask

  task automatic expect_done(input string tag, input bit fin_start);
    vec_t e;
    vec_t got;
    logic signed [ACC_W-1:0] sh;
    int cycles;
    bit seen;
    for (int ch = 0; ch < 10; ch++) begin
      sh = model_acc[ch] >>> LOG2_N;
      e[ch] = sh[IN_W-1:0];
    end
    exp_q.push_back(e);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < 12) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      cycles++;
      if (cycles == 1) begin
        checkOutput({tag, "_busy_fin"}, {63'b0, busy}, 64'd1);
        if (fin_start) begin
          start    = 1'b1;
          in_valid = 1'b1;
          model_clear();
        end
      end
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checkOutput({tag, "_done_timeout"}, 64'd0, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      checkOutput({tag, "_latency"}, 64'(cycles), 64'd2);
      got = exp_q.pop_front();
      for (int ch = 0; ch < 10; ch++) begin
        checkOutput({tag, "_", nm[ch]}, {12'b0, c_w[ch]}, {12'b0, got[ch]});
      end
      checkOutput({tag, "_busy_at_done"}, {63'b0, busy}, {63'b0, fin_start});
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, "_done_width"}, {63'b0, done}, 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   dc;

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    x_tb     = '0;
    model_clear();
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_done", {63'b0, done}, 64'd0);
    check_const("reset_C11", 0, '0);
    check_const("reset_C44", 9, '0);
    rst = 1'b0;

    // Constant products
    $display("[TB] constant run");
    dc = done_count;
    do_start(1'b0);
    applyStimulus(all_of(IN_W'(1000)), 128, 0, 1'b0);
    expect_done("const", 1'b0);
    check_const("const_C11_lit", 0, IN_W'(1000));
    check_const("const_C34_lit", 8, IN_W'(1000));
    @(negedge clk);
    checkOutput("const_one_done", 64'(done_count), 64'(dc + 1));

    // Async reset mid-estimate
    $display("[TB] reset mid-estimate");
    do_start(1'b0);
    applyStimulus(all_of(IN_W'(11)), 40, 0, 1'b0);
    #3 rst = 1'b1;
    #1;
    for (int ch = 0; ch < 10; ch++) check_const({"rst_", nm[ch]}, ch, '0);
    checkOutput("rst_busy", {63'b0, busy}, 64'd0);
    checkOutput("rst_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    model_clear();
    dc = done_count;
    repeat (4) @(negedge clk);
    checkOutput("rst_no_done", 64'(done_count), 64'(dc));
    v = '0;
    v[0] = IN_W'(5);
    do_start(1'b0);
    applyStimulus(v, 128, 0, 1'b0);
    expect_done("post_rst", 1'b0);
    check_const("post_rst_C11_lit", 0, IN_W'(5));

    // Sign and floor behaviour
    $display("[TB] sign and floor");
    v = '0;
    v[1] = IN_W'(-3);
    v[7] = IN_W'(-1000);
    v[0] = IN_W'(12345);
    do_start(1'b0);
    applyStimulus(v, 128, 0, 1'b0);
    expect_done("neg3", 1'b0);
    check_const("neg3_C12_lit", 1, IN_W'(-3));
    v = '0;
    v[1] = IN_W'(-1);
    v[5] = IN_W'(1);
    do_start(1'b0);
    applyStimulus(v, 64, 0, 1'b0);
    applyStimulus('0, 64, 0, 1'b0);
    expect_done("floor", 1'b0);
    check_const("floor_C12_lit", 1, IN_W'(-1));
    check_const("floor_C23_lit", 5, '0);

    // Gapped valid, with in_valid pulses while idle
    $display("[TB] gapped valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_tb     = all_of(IN_W'(99));
    end
    dc = done_count;
    v = '0;
    v[8] = IN_W'(7);
    do_start(1'b0);
    applyStimulus(v, 128, 2, 1'b0);
    expect_done("gap", 1'b0);
    check_const("gap_C34_lit", 8, IN_W'(7));
    @(negedge clk);
    checkOutput("gap_one_done", 64'(done_count), 64'(dc + 1));

    // Extremes
    $display("[TB] extremes");
    v = '0;
    v[9] = {1'b0, {(IN_W-1){1'b1}}};
    v[3] = {1'b1, {(IN_W-1){1'b0}}};
    v[4] = {1'b1, {(IN_W-1){1'b0}}};
    v[6] = {1'b0, {(IN_W-1){1'b1}}};
    do_start(1'b0);
    applyStimulus(v, 128, 0, 1'b0);
    expect_done("extreme", 1'b0);
    check_const("extreme_C44_lit", 9, {1'b0, {(IN_W-1){1'b1}}});
    check_const("extreme_C14_lit", 3, {1'b1, {(IN_W-1){1'b0}}});

    // Restart mid-run: start in ACC with in_valid high must win
    $display("[TB] restart");
    dc = done_count;
    do_start(1'b0);
    applyStimulus(all_of(IN_W'(9)), 50, 0, 1'b0);
    do_start(1'b1);
    applyStimulus(all_of(IN_W'(2)), 128, 0, 1'b0);
    expect_done("restart", 1'b0);
    check_const("restart_C22_lit", 4, IN_W'(2));
    repeat (2) @(negedge clk);
    checkOutput("restart_one_done", 64'(done_count), 64'(dc + 1));

    // start during FIN: results commit, new run begins cleared
    $display("[TB] start in FIN");
    do_start(1'b0);
    applyStimulus(all_of(IN_W'(3)), 128, 0, 1'b0);
    expect_done("fin_start_a", 1'b1);
    check_const("fin_start_a_C33_lit", 7, IN_W'(3));
    applyStimulus(all_of(IN_W'(-5)), 128, 0, 1'b0);
    expect_done("fin_start_b", 1'b0);
    check_const("fin_start_b_C13_lit", 2, IN_W'(-5));

    // Hold: outputs unchanged while idle
    repeat (5) @(negedge clk);
    check_const("hold_C13", 2, IN_W'(-5));

    // Random full-range products with gaps
    $display("[TB] random run");
    do_start(1'b0);
    applyStimulus('0, 128, 1, 1'b1);
    expect_done("random", 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
